// File: rtl/mul_issue_ctrl.sv
// Issue/retire sequencer for the three-stage multiplier: decodes MUL ops for x0,
// tracks in-flight destinations in a tag FIFO and retires them in order from x2.
// Optional RAW stall against in-flight destinations: define MUL_HAZARD_CHECK_EN.
module mul_issue_ctrl #(
   parameter int DEPTH = 4,
   parameter int RD_W  = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            DEC_MUL_VALID_SD,
   input  logic [1:0]      DEC_MUL_OP_SD,
   input  logic [RD_W-1:0] DEC_MUL_RD_SD,
   output logic            DEC_MUL_READY_SD,
   input  logic            FLUSH_SX,
   output logic            X0_PUSH_SX0,
   output logic            SIGNED_RES_SX0,
   output logic            SELECT_MSB_SX0,
   input  logic            X2_DONE_SX2,
   output logic            WB_VALID_SX2,
   output logic [RD_W-1:0] WB_RD_SX2,
   output logic            MUL_BUSY_SX,
   output logic            ERR_UNDERFLOW
`ifdef MUL_HAZARD_CHECK_EN
   ,
   input  logic [RD_W-1:0] HAZ_RS1_SD,
   input  logic [RD_W-1:0] HAZ_RS2_SD,
   output logic            HAZ_STALL_SD
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [RD_W-1:0]  rd_q [DEPTH];
   logic [DEPTH-1:0] kill_q;
   logic             underflow_q;
   logic             accept;
   logic             pop;
   logic             haz_stall;

   function automatic logic op_signed(input logic [1:0] op);
      return op != 2'b11;
   endfunction

   function automatic logic op_high(input logic [1:0] op);
      return op != 2'b00;
   endfunction

   assign SIGNED_RES_SX0 = op_signed(DEC_MUL_OP_SD);
   assign SELECT_MSB_SX0 = op_high(DEC_MUL_OP_SD);
   assign ERR_UNDERFLOW  = underflow_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // READY is computed from the current count only, so a completion on a full cycle
   // frees the slot for the following cycle rather than this one.
   always_comb begin
      DEC_MUL_READY_SD = (state != ST_DRAIN) && (count < FULL_CNT) && !FLUSH_SX && !haz_stall;
      accept           = DEC_MUL_VALID_SD && DEC_MUL_READY_SD;
      pop              = X2_DONE_SX2 && (count != '0);
      count_nxt        = count + CNT_W'(accept) - CNT_W'(pop);
      state_nxt        = state;
      X0_PUSH_SX0      = accept;
      WB_VALID_SX2     = pop && !kill_q[rd_ptr] && !FLUSH_SX;
      WB_RD_SX2        = (count != '0) ? rd_q[rd_ptr] : '0;
      MUL_BUSY_SX      = (count != '0);
      if (FLUSH_SX) begin
         state_nxt = (count_nxt != '0) ? ST_DRAIN : ST_IDLE;
      end else begin
         case (state)
            ST_DRAIN: if (count_nxt == '0) state_nxt = ST_IDLE;
            default:  state_nxt = (count_nxt == '0) ? ST_IDLE : ST_RUN;
         endcase
      end
   end

   // Flush never coincides with an accept (READY is low), so marking every slot
   // killed is equivalent to marking only the occupied ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         kill_q      <= '0;
         underflow_q <= 1'b0;
      end else begin
         count <= count_nxt;
         if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (FLUSH_SX) kill_q <= '1;
         if (accept) kill_q[wr_ptr] <= 1'b0;
         if (X2_DONE_SX2 && (count == '0)) underflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) rd_q[wr_ptr] <= DEC_MUL_RD_SD;
   end

`ifdef MUL_HAZARD_CHECK_EN
   // A slot is occupied when its distance from the head is below the count.
   always_comb begin
      haz_stall = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count) && !kill_q[i] && (rd_q[i] != '0) &&
             ((rd_q[i] == HAZ_RS1_SD) || (rd_q[i] == HAZ_RS2_SD)))
            haz_stall = 1'b1;
      end
   end
   assign HAZ_STALL_SD = haz_stall;
`else
   assign haz_stall = 1'b0;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl: directed issue/complete/flush sequences with
// expected x0 pushes and writebacks queued at issue and checked by a monitor.
module tb_mul_issue_ctrl;
   localparam int DEPTH = 4;
   localparam int RD_W  = 5;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            DEC_MUL_VALID_SD;
   logic [1:0]      DEC_MUL_OP_SD;
   logic [RD_W-1:0] DEC_MUL_RD_SD;
   logic            DEC_MUL_READY_SD;
   logic            FLUSH_SX;
   logic            X0_PUSH_SX0;
   logic            SIGNED_RES_SX0;
   logic            SELECT_MSB_SX0;
   logic            X2_DONE_SX2;
   logic            WB_VALID_SX2;
   logic [RD_W-1:0] WB_RD_SX2;
   logic            MUL_BUSY_SX;
   logic            ERR_UNDERFLOW;
`ifdef MUL_HAZARD_CHECK_EN
   logic [RD_W-1:0] HAZ_RS1_SD;
   logic [RD_W-1:0] HAZ_RS2_SD;
   logic            HAZ_STALL_SD;
`endif

   typedef struct packed {
      logic sgn;
      logic msb;
   } push_t;

   push_t           exp_push_q[$];
   logic [RD_W-1:0] exp_wb_q[$];
   int              checks = 0;
   int              errors = 0;

   localparam logic [3:0] SGN_TAB = 4'b0111;
   localparam logic [3:0] MSB_TAB = 4'b1110;

   mul_issue_ctrl #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .DEC_MUL_VALID_SD(DEC_MUL_VALID_SD),
      .DEC_MUL_OP_SD(DEC_MUL_OP_SD),
      .DEC_MUL_RD_SD(DEC_MUL_RD_SD),
      .DEC_MUL_READY_SD(DEC_MUL_READY_SD),
      .FLUSH_SX(FLUSH_SX),
      .X0_PUSH_SX0(X0_PUSH_SX0),
      .SIGNED_RES_SX0(SIGNED_RES_SX0),
      .SELECT_MSB_SX0(SELECT_MSB_SX0),
      .X2_DONE_SX2(X2_DONE_SX2),
      .WB_VALID_SX2(WB_VALID_SX2),
      .WB_RD_SX2(WB_RD_SX2),
      .MUL_BUSY_SX(MUL_BUSY_SX),
      .ERR_UNDERFLOW(ERR_UNDERFLOW)
`ifdef MUL_HAZARD_CHECK_EN
      ,
      .HAZ_RS1_SD(HAZ_RS1_SD),
      .HAZ_RS2_SD(HAZ_RS2_SD),
      .HAZ_STALL_SD(HAZ_STALL_SD)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr();
      DEC_MUL_VALID_SD = 1'b0;
      DEC_MUL_OP_SD    = 2'b00;
      DEC_MUL_RD_SD    = '0;
      X2_DONE_SX2      = 1'b0;
      FLUSH_SX         = 1'b0;
`ifdef MUL_HAZARD_CHECK_EN
      HAZ_RS1_SD       = '0;
      HAZ_RS2_SD       = '0;
`endif
   endtask

   task automatic issue(input logic [1:0] op, input logic [RD_W-1:0] rd,
                        input logic sgn, input logic msb, input logic retire);
      DEC_MUL_VALID_SD = 1'b1;
      DEC_MUL_OP_SD    = op;
      DEC_MUL_RD_SD    = rd;
      exp_push_q.push_back(push_t'({sgn, msb}));
      if (retire) exp_wb_q.push_back(rd);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      clr();
   endtask

   // Monitor: every x0 push and every writeback must match the head of its queue.
   always @(negedge clk) begin
      push_t           e;
      logic [RD_W-1:0] r;
      if (reset_n) begin
         if (X0_PUSH_SX0) begin
            if (exp_push_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL push_unexpected: got push expected none");
            end else begin
               e = exp_push_q.pop_front();
               chk("push_signed", 32'(SIGNED_RES_SX0), 32'(e.sgn));
               chk("push_msb", 32'(SELECT_MSB_SX0), 32'(e.msb));
            end
         end
         if (WB_VALID_SX2) begin
            if (exp_wb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wb_unexpected: got wb rd=%0d expected none", WB_RD_SX2);
            end else begin
               r = exp_wb_q.pop_front();
               chk("wb_rd", 32'(WB_RD_SX2), 32'(r));
            end
         end
      end
   end

   initial begin
      clr();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(DEC_MUL_READY_SD), 32'd1);
      chk("rst_push", 32'(X0_PUSH_SX0), 32'd0);
      chk("rst_wb_valid", 32'(WB_VALID_SX2), 32'd0);
      chk("rst_wb_rd", 32'(WB_RD_SX2), 32'd0);
      chk("rst_busy", 32'(MUL_BUSY_SX), 32'd0);
      chk("rst_err", 32'(ERR_UNDERFLOW), 32'd0);
      reset_n = 1'b1;
      next();

      // Single MULH to rd 7, completes three cycles after issue
      issue(2'b01, 5'd7, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("t1_ready", 32'(DEC_MUL_READY_SD), 32'd1);
      chk("t1_push", 32'(X0_PUSH_SX0), 32'd1);
      next();
      @(negedge clk);
      chk("t1_busy", 32'(MUL_BUSY_SX), 32'd1);
      next();
      next();
      X2_DONE_SX2 = 1'b1;
      @(negedge clk);
      chk("t1_wb_valid", 32'(WB_VALID_SX2), 32'd1);
      chk("t1_wb_rd", 32'(WB_RD_SX2), 32'd7);
      chk("t1_busy_done", 32'(MUL_BUSY_SX), 32'd1);
      next();
      @(negedge clk);
      chk("t1_busy_after", 32'(MUL_BUSY_SX), 32'd0);
      chk("t1_wb_rd_idle", 32'(WB_RD_SX2), 32'd0);
      next();

      // Fill four slots, then stall
      for (int i = 1; i <= 4; i++) begin
         issue(2'b00, 5'(i), 1'b1, 1'b0, 1'b1);
         @(negedge clk);
         chk("t2_ready_fill", 32'(DEC_MUL_READY_SD), 32'd1);
         next();
      end
      DEC_MUL_VALID_SD = 1'b1;
      DEC_MUL_RD_SD    = 5'd9;
      @(negedge clk);
      chk("t2_ready_full", 32'(DEC_MUL_READY_SD), 32'd0);
      next();
      DEC_MUL_VALID_SD = 1'b1;
      DEC_MUL_RD_SD    = 5'd9;
      X2_DONE_SX2      = 1'b1;
      @(negedge clk);
      chk("t2_ready_full_done", 32'(DEC_MUL_READY_SD), 32'd0);
      chk("t2_wb_rd", 32'(WB_RD_SX2), 32'd1);
      next();
      @(negedge clk);
      chk("t2_ready_reopen", 32'(DEC_MUL_READY_SD), 32'd1);
      next();
      repeat (3) begin
         X2_DONE_SX2 = 1'b1;
         next();
      end
      @(negedge clk);
      chk("t2_busy_empty", 32'(MUL_BUSY_SX), 32'd0);
      next();

      // Ten back-to-back ops, completing one per cycle; pointers wrap twice
      for (int k = 0; k < 10; k++) begin
         issue(2'(k % 4), 5'(10 + k), SGN_TAB[k % 4], MSB_TAB[k % 4], 1'b1);
         if (k > 0) X2_DONE_SX2 = 1'b1;
         @(negedge clk);
         if (k > 0) begin
            chk("t3_busy", 32'(MUL_BUSY_SX), 32'd1);
            chk("t3_ready", 32'(DEC_MUL_READY_SD), 32'd1);
            chk("t3_head_rd", 32'(WB_RD_SX2), 32'(9 + k));
         end
         next();
      end
      X2_DONE_SX2 = 1'b1;
      next();
      @(negedge clk);
      chk("t3_busy_end", 32'(MUL_BUSY_SX), 32'd0);
      next();

      // Flush with three in flight: drain without writeback
      for (int i = 0; i < 3; i++) begin
         issue(2'b10, 5'(20 + i), 1'b1, 1'b1, 1'b0);
         next();
      end
      FLUSH_SX         = 1'b1;
      DEC_MUL_VALID_SD = 1'b1;
      DEC_MUL_RD_SD    = 5'd23;
      @(negedge clk);
      chk("t4_ready_flush", 32'(DEC_MUL_READY_SD), 32'd0);
      next();
      DEC_MUL_VALID_SD = 1'b1;
      DEC_MUL_RD_SD    = 5'd23;
      @(negedge clk);
      chk("t4_ready_drain", 32'(DEC_MUL_READY_SD), 32'd0);
      chk("t4_busy_drain", 32'(MUL_BUSY_SX), 32'd1);
      next();
      repeat (3) begin
         DEC_MUL_VALID_SD = 1'b1;
         DEC_MUL_RD_SD    = 5'd23;
         X2_DONE_SX2      = 1'b1;
         @(negedge clk);
         chk("t4_wb_killed", 32'(WB_VALID_SX2), 32'd0);
         chk("t4_ready_draining", 32'(DEC_MUL_READY_SD), 32'd0);
         next();
      end
      issue(2'b11, 5'd23, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("t4_ready_after", 32'(DEC_MUL_READY_SD), 32'd1);
      next();
      X2_DONE_SX2 = 1'b1;
      next();

      // Flush coinciding with completion, then underflow
      issue(2'b10, 5'd30, 1'b1, 1'b1, 1'b0);
      next();
      FLUSH_SX    = 1'b1;
      X2_DONE_SX2 = 1'b1;
      @(negedge clk);
      chk("t5_wb_suppressed", 32'(WB_VALID_SX2), 32'd0);
      chk("t5_wb_rd", 32'(WB_RD_SX2), 32'd30);
      next();
      @(negedge clk);
      chk("t5_ready_idle", 32'(DEC_MUL_READY_SD), 32'd1);
      chk("t5_busy_idle", 32'(MUL_BUSY_SX), 32'd0);
      chk("t5_err_clear", 32'(ERR_UNDERFLOW), 32'd0);
      next();
      X2_DONE_SX2 = 1'b1;
      @(negedge clk);
      chk("t5_uf_wb", 32'(WB_VALID_SX2), 32'd0);
      next();
      @(negedge clk);
      chk("t5_err_set", 32'(ERR_UNDERFLOW), 32'd1);
      chk("t5_uf_busy", 32'(MUL_BUSY_SX), 32'd0);
      next();
      issue(2'b00, 5'd31, 1'b1, 1'b0, 1'b1);
      next();
      X2_DONE_SX2 = 1'b1;
      @(negedge clk);
      chk("t5_post_uf_rd", 32'(WB_RD_SX2), 32'd31);
      chk("t5_err_sticky", 32'(ERR_UNDERFLOW), 32'd1);
      next();

      // Reset with ops in flight discards them
      issue(2'b00, 5'd17, 1'b1, 1'b0, 1'b0);
      next();
      issue(2'b01, 5'd18, 1'b1, 1'b1, 1'b0);
      next();
      reset_n = 1'b0;
      #2;
      chk("rr_busy", 32'(MUL_BUSY_SX), 32'd0);
      chk("rr_err", 32'(ERR_UNDERFLOW), 32'd0);
      chk("rr_ready", 32'(DEC_MUL_READY_SD), 32'd1);
      chk("rr_wb_rd", 32'(WB_RD_SX2), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      next();
      X2_DONE_SX2 = 1'b1;
      @(negedge clk);
      chk("rr_no_wb", 32'(WB_VALID_SX2), 32'd0);
      next();

`ifdef MUL_HAZARD_CHECK_EN
      issue(2'b01, 5'd5, 1'b1, 1'b1, 1'b1);
      next();
      DEC_MUL_VALID_SD = 1'b1;
      DEC_MUL_RD_SD    = 5'd9;
      HAZ_RS1_SD       = 5'd5;
      @(negedge clk);
      chk("haz_rs1_stall", 32'(HAZ_STALL_SD), 32'd1);
      chk("haz_ready", 32'(DEC_MUL_READY_SD), 32'd0);
      next();
      HAZ_RS1_SD = 5'd3;
      HAZ_RS2_SD = 5'd5;
      @(negedge clk);
      chk("haz_rs2_stall", 32'(HAZ_STALL_SD), 32'd1);
      next();
      X2_DONE_SX2 = 1'b1;
      next();
      issue(2'b00, 5'd0, 1'b1, 1'b0, 1'b1);
      next();
      X2_DONE_SX2 = 1'b1;
      @(negedge clk);
      chk("haz_rd0", 32'(HAZ_STALL_SD), 32'd0);
      chk("haz_rd0_ready", 32'(DEC_MUL_READY_SD), 32'd1);
      next();
      issue(2'b00, 5'd6, 1'b1, 1'b0, 1'b0);
      next();
      FLUSH_SX = 1'b1;
      next();
      HAZ_RS1_SD = 5'd6;
      @(negedge clk);
      chk("haz_killed", 32'(HAZ_STALL_SD), 32'd0);
      next();
      X2_DONE_SX2 = 1'b1;
      next();
`endif

      repeat (3) next();
      chk("push_q_empty", 32'(exp_push_q.size()), 32'd0);
      chk("wb_q_empty", 32'(exp_wb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
